// File: rtl/axis_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that multiplexes N AXI-Stream inputs onto one FIFO write port.
// Each FIFO word carries {source id, tlast, tdata} so the read side can demultiplex packets.
module axis_fifo_wr_arbiter #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN-1:0]          s_tvalid,
  input  logic [N_IN*DATA_W-1:0]   s_tdata,
  input  logic [N_IN-1:0]          s_tlast,
  output logic [N_IN-1:0]          s_tready,
  input  logic                     fifo_full,
  output logic                     fifo_wen,
  output logic [ID_W+DATA_W:0]     fifo_wdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy
);

  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e            state_q;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic              busy_q;

  logic [ID_W-1:0]   pick_d;
  logic              pick_vld_d;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [SEL_W-1:0]  cand_sel;
  int unsigned       cand;

  logic [SEL_W-1:0]  gsel;
  logic              g_valid;
  logic              g_last;
  logic [DATA_W-1:0] data_arr [N_IN];

  assign gsel    = grant_q[SEL_W-1:0];
  assign g_valid = s_tvalid[gsel];
  assign g_last  = s_tlast[gsel];

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      data_arr[i] = s_tdata[i*DATA_W +: DATA_W];
    end
  end

  // Search from rr_ptr upward; iterating downward lets the nearest requester overwrite the others.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_d     = '0;
    cand       = 0;
    cand_sel   = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr_q) + k) % N_IN;
      cand_sel = SEL_W'(cand);
      if (s_tvalid[cand_sel]) begin
        pick_vld_d = 1'b1;
        pick_d     = ID_W'(cand_sel);
      end
    end
  end

  assign rr_ptr_d = ID_W'((int'(grant_q) + 1) % N_IN);

  // Handshake outputs are gated by the state register, so an asynchronous reset silences them at once.
  assign fifo_wen = (state_q == LOCK) & g_valid & ~fifo_full;

  always_comb begin
    s_tready   = '0;
    fifo_wdata = '0;
    if (state_q == LOCK) begin
      s_tready[gsel] = ~fifo_full;
      fifo_wdata     = {grant_q, g_last, data_arr[gsel]};
    end
  end

  // The grant is released only by a written tlast beat, never by idle cycles or competing requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q <= LOCK;
            grant_q <= pick_d;
            busy_q  <= 1'b1;
          end
        end
        LOCK: begin
          if (fifo_wen && g_last) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_fifo_wr_arbiter.sv
// Randomized bench for axis_fifo_wr_arbiter: AXIS sources fed from packet queues, a cycle model of the
// arbitration rules, and per-source stream scoreboards on the words written into the FIFO.
module tb_axis_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int WW = IW + 1 + DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N-1:0]    s_tready;
  logic            fifo_full = 1'b0;
  logic            fifo_wen;
  logic [WW-1:0]   fifo_wdata;
  logic [IW-1:0]   grant_id;
  logic            busy;

  axis_fifo_wr_arbiter #(.N_IN(N), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit [DW:0]     srcQ    [N][$];
  bit [WW-1:0]   sentLog [N][$];
  logic [WW-1:0] wrLog   [$];
  bit            acc     [N];
  int            pValid = 100;
  int            pFull  = 0;

  bit mLocked;
  int mGrant;
  int mRr;

  bit fairMode;
  int fairIdx;
  int idleRun;
  bit prevBusy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pushPacket(input int src, input int len, input bit randData, input int base);
    bit [DW-1:0] d;
    bit l;
    for (int b = 0; b < len; b++) begin
      d = randData ? DW'($urandom) : DW'(base + b);
      l = (b == len - 1);
      srcQ[src].push_back({l, d});
      sentLog[src].push_back({IW'(src), l, d});
    end
  endtask

  // Sources obey AXIS: a presented beat is held until accepted, new beats appear with probability pValid.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && !acc[i]) begin
        s_tvalid[i] = 1'b1;
      end else if (srcQ[i].size() > 0 && $urandom_range(99) < pValid) begin
        s_tvalid[i] = 1'b1;
        {s_tlast[i], s_tdata[i*DW +: DW]} = srcQ[i][0];
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    fifo_full = ($urandom_range(99) < pFull);
  endtask

  task automatic stepCycle();
    logic [N-1:0]  expRdy;
    logic          expWen;
    logic [WW-1:0] expWd;
    bit            found;
    @(negedge clk);
    applyStimulus();
    #1;
    expRdy = '0;
    expWen = 1'b0;
    expWd  = '0;
    if (mLocked) begin
      expRdy[mGrant] = !fifo_full;
      expWen = s_tvalid[mGrant] && !fifo_full;
      expWd  = {IW'(mGrant), s_tlast[mGrant], s_tdata[mGrant*DW +: DW]};
    end
    checkOutput("tready", s_tready, expRdy);
    checkOutput("wen", fifo_wen, expWen);
    checkOutput("wdata", fifo_wdata, expWd);
    checkOutput("grant_id", grant_id, mLocked ? mGrant : 0);
    checkOutput("busy", busy, mLocked);

    if (!busy) begin
      idleRun++;
    end else if (!prevBusy) begin
      if (fairMode) begin
        checkOutput("rrOrder", grant_id, fairIdx % N);
        if (fairIdx > 0) checkOutput("gap", idleRun, 1);
        fairIdx++;
      end
      idleRun = 0;
    end
    prevBusy = busy;

    for (int i = 0; i < N; i++) begin
      acc[i] = s_tvalid[i] && s_tready[i];
      if (acc[i]) void'(srcQ[i].pop_front());
    end
    if (fifo_wen) wrLog.push_back(fifo_wdata);

    if (!mLocked) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (mRr + k) % N;
        if (!found && s_tvalid[c]) begin
          found   = 1'b1;
          mLocked = 1'b1;
          mGrant  = c;
        end
      end
    end else if (expWen && s_tlast[mGrant]) begin
      mLocked = 1'b0;
      mRr = (mGrant + 1) % N;
    end
  endtask

  task automatic runUntilDrained(input int budget);
    int n;
    bit pending;
    n = 0;
    do begin
      stepCycle();
      n++;
      pending = mLocked;
      for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) pending = 1'b1;
    end while (pending && n < budget);
    if (pending) checkOutput("drainTimeout", n, 0);
  endtask

  // Each source's words must arrive complete, in order and with their own id.
  task automatic checkStreams();
    int k;
    for (int i = 0; i < N; i++) begin
      k = 0;
      foreach (wrLog[j]) begin
        if (int'(wrLog[j][WW-1 -: IW]) == i) begin
          if (k < sentLog[i].size()) checkOutput("stream", wrLog[j], sentLog[i][k]);
          k++;
        end
      end
      checkOutput("streamLen", k, sentLog[i].size());
      sentLog[i].delete();
    end
    wrLog.delete();
  endtask

  initial begin
    int cnt [N];
    int n;

    #2;
    checkOutput("rst_tready", s_tready, 0);
    checkOutput("rst_wen", fifo_wen, 0);
    checkOutput("rst_wdata", fifo_wdata, 0);
    checkOutput("rst_grant", grant_id, 0);
    checkOutput("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all inputs always valid, 4 two-beat packets each, FIFO never full.
    fairMode = 1'b1;
    fairIdx  = 0;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < N; i++) pushPacket(i, 2, 1'b1, 0);
    runUntilDrained(500);
    fairMode = 1'b0;
    checkOutput("fairPkts", fairIdx, 16);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (wrLog[j]) if (wrLog[j][DW]) cnt[wrLog[j][WW-1 -: IW]]++;
    for (int i = 0; i < N; i++) checkOutput("fairShare", cnt[i], 4);
    checkStreams();

    // Single three-beat packet on input 2.
    pushPacket(2, 3, 1'b0, 8'h10);
    runUntilDrained(100);
    checkOutput("single0", wrLog.size() > 0 ? wrLog[0] : '0, {2'd2, 1'b0, 8'h10});
    checkOutput("single1", wrLog.size() > 1 ? wrLog[1] : '0, {2'd2, 1'b0, 8'h11});
    checkOutput("single2", wrLog.size() > 2 ? wrLog[2] : '0, {2'd2, 1'b1, 8'h12});
    checkStreams();

    // Wrap-around: pointer is at 3, grant 3, then 0 and 3 compete and 0 wins.
    pushPacket(3, 1, 1'b1, 0);
    runUntilDrained(100);
    checkStreams();
    pushPacket(0, 2, 1'b1, 0);
    pushPacket(3, 1, 1'b1, 0);
    runUntilDrained(100);
    checkOutput("wrapFirst", wrLog.size() > 0 ? wrLog[0][WW-1 -: IW] : 2'd1, 0);
    checkOutput("wrapLast", wrLog.size() > 2 ? wrLog[2][WW-1 -: IW] : 2'd1, 3);
    checkStreams();

    // Random traffic with source gaps and FIFO backpressure.
    pValid = 70;
    pFull  = 25;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) pushPacket(i, $urandom_range(5, 1), 1'b1, 0);
    runUntilDrained(3000);
    checkStreams();

    // Leave the pointer at 3, then reset during beat 2 of a five-beat packet on input 1.
    pValid = 100;
    pFull  = 0;
    pushPacket(2, 1, 1'b1, 0);
    runUntilDrained(100);
    checkStreams();
    pushPacket(1, 5, 1'b0, 8'h20);
    n = 0;
    while (srcQ[1].size() > 4 && n < 50) begin
      stepCycle();
      n++;
    end
    checkOutput("midPktReached", srcQ[1].size(), 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tready", s_tready, 0);
    checkOutput("arst_wen", fifo_wen, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_grant", grant_id, 0);
    checkOutput("arst_wdata", fifo_wdata, 0);
    s_tvalid = '0;
    for (int i = 0; i < N; i++) begin
      srcQ[i].delete();
      sentLog[i].delete();
      acc[i] = 1'b0;
    end
    wrLog.delete();
    mLocked  = 1'b0;
    mGrant   = 0;
    mRr      = 0;
    prevBusy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pushPacket(2, 2, 1'b1, 0);
    pushPacket(3, 2, 1'b1, 0);
    runUntilDrained(100);
    checkOutput("postRstFirst", wrLog.size() > 0 ? wrLog[0][WW-1 -: IW] : 2'd0, 2);
    checkStreams();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
